addr_gen_hc_seq: RTL and testbench

ADDR_GEN_HC_SEQ -- requirements
Module: addr_gen_hc_seq

---
 rtl/addr_gen_hc_seq.sv | 204 ++++++++++++++++++++
 tb/tb_addr_gen_hc_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_gen_hc_seq.sv
// H/C read-address sequencer: per timestep row, sweeps every h address once per cell.
// Define ADDR_GEN_HC_REVERSE_EN to honour i_dir (reverse timestep order).
module addr_gen_hc_seq #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMESTEP   = 7,
  parameter int NUM_CELL   = 53,
  parameter int DELAY      = 3,
  parameter logic [ADDR_WIDTH-1:0] H_BASE = '0,
  parameter logic [ADDR_WIDTH-1:0] C_BASE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_en,
  input  logic                  i_dir,
  output logic [ADDR_WIDTH-1:0] o_addr_h,
  output logic [ADDR_WIDTH-1:0] o_addr_c,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] NC     = AW'(NUM_CELL);
  localparam logic [AW-1:0] NC_M1  = AW'(NUM_CELL - 1);
  localparam logic [AW-1:0] TS_M1  = AW'(TIMESTEP - 1);
  localparam logic [AW-1:0] GAP_M1 = AW'((DELAY > 0) ? DELAY - 1 : 0);
  localparam logic          LAST0  = (NUM_CELL == 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] j_q, j_d;
  logic [AW-1:0] t_q, t_d;
  logic [AW-1:0] r_q, r_d;
  logic [AW-1:0] g_q, g_d;
  logic [AW-1:0] addr_h_q, addr_h_d;
  logic [AW-1:0] addr_c_q, addr_c_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [AW-1:0] r_st;
  logic [AW-1:0] t_st;
  logic [AW-1:0] t_nx;
  logic [AW-1:0] r_nx;
  logic          sweep_end;

`ifdef ADDR_GEN_HC_REVERSE_EN
  localparam logic [AW-1:0] R_TOP = AW'((TIMESTEP - 1) * NUM_CELL);
  logic dir_q, dir_d;

  always_comb begin
    r_st      = i_dir ? R_TOP : '0;
    t_st      = i_dir ? TS_M1 : '0;
    t_nx      = dir_q ? t_q - AW'(1) : t_q + AW'(1);
    r_nx      = dir_q ? r_q - NC : r_q + NC;
    sweep_end = dir_q ? (t_q == '0) : (t_q == TS_M1);
    dir_d     = dir_q;
    if (i_en && state_q == S_IDLE && i_start) dir_d = i_dir;
  end
`else
  logic unused_dir;
  assign unused_dir = i_dir;

  always_comb begin
    r_st      = '0;
    t_st      = '0;
    t_nx      = t_q + AW'(1);
    r_nx      = r_q + NC;
    sweep_end = (t_q == TS_M1);
  end
`endif

  always_comb begin
    logic adv;
    adv      = 1'b0;
    state_d  = state_q;
    k_d      = k_q;
    j_d      = j_q;
    t_d      = t_q;
    r_d      = r_q;
    g_d      = g_q;
    addr_h_d = addr_h_q;
    addr_c_d = addr_c_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = done_q;
    if (i_en) begin
      unique case (state_q)
        S_IDLE: if (i_start) begin
          state_d  = S_SWEEP;
          k_d      = '0;
          j_d      = '0;
          t_d      = t_st;
          r_d      = r_st;
          addr_h_d = H_BASE + r_st;
          addr_c_d = C_BASE + r_st;
          valid_d  = 1'b1;
          last_d   = LAST0;
          busy_d   = 1'b1;
        end
        S_SWEEP: if (k_q != NC_M1) begin
          k_d      = k_q + AW'(1);
          addr_h_d = addr_h_q + AW'(1);
          last_d   = (k_q + AW'(1) == NC_M1);
        end else if (DELAY == 0) begin
          adv = 1'b1;
        end else begin
          state_d = S_GAP;
          g_d     = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
        S_GAP: if (g_q == GAP_M1) adv = 1'b1;
               else g_d = g_q + AW'(1);
        S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
      // cell finished (after any gap): next cell, next row, or done
      if (adv) begin
        k_d = '0;
        if (j_q != NC_M1) begin
          state_d  = S_SWEEP;
          j_d      = j_q + AW'(1);
          addr_h_d = H_BASE + r_q;
          addr_c_d = C_BASE + r_q + j_q + AW'(1);
          valid_d  = 1'b1;
          last_d   = LAST0;
        end else if (sweep_end) begin
          state_d = S_DONE;
          j_d     = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d  = S_SWEEP;
          j_d      = '0;
          t_d      = t_nx;
          r_d      = r_nx;
          addr_h_d = H_BASE + r_nx;
          addr_c_d = C_BASE + r_nx;
          valid_d  = 1'b1;
          last_d   = LAST0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      j_q      <= '0;
      t_q      <= '0;
      r_q      <= '0;
      g_q      <= '0;
      addr_h_q <= H_BASE;
      addr_c_q <= C_BASE;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ADDR_GEN_HC_REVERSE_EN
      dir_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      j_q      <= j_d;
      t_q      <= t_d;
      r_q      <= r_d;
      g_q      <= g_d;
      addr_h_q <= addr_h_d;
      addr_c_q <= addr_c_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ADDR_GEN_HC_REVERSE_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign o_addr_h = addr_h_q;
  assign o_addr_c = addr_c_q;
  assign o_valid  = valid_q;
  assign o_last   = last_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_addr_gen_hc_seq.sv
// Scoreboard bench for addr_gen_hc_seq: NUM_CELL=3, TIMESTEP=2,
// DELAY=1 (inst a) and DELAY=0 with nonzero bases (inst b).
module tb_addr_gen_hc_seq;

  localparam int NC = 3;
  localparam int TS = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, en_a, dir_a;
  logic start_b, en_b, dir_b;
  logic [11:0] ha, ca, hb, cb;
  logic va, la, busy_a, done_a;
  logic vb, lb, busy_b, done_b;

  always #5 clk = ~clk;

  addr_gen_hc_seq #(
    .ADDR_WIDTH(12), .TIMESTEP(TS), .NUM_CELL(NC), .DELAY(1),
    .H_BASE(12'd0), .C_BASE(12'd0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .i_start(start_a), .i_en(en_a),
    .i_dir(dir_a), .o_addr_h(ha), .o_addr_c(ca), .o_valid(va),
    .o_last(la), .o_busy(busy_a), .o_done(done_a)
  );

  addr_gen_hc_seq #(
    .ADDR_WIDTH(12), .TIMESTEP(TS), .NUM_CELL(NC), .DELAY(0),
    .H_BASE(12'd100), .C_BASE(12'd200)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .i_start(start_b), .i_en(en_b),
    .i_dir(dir_b), .o_addr_h(hb), .o_addr_c(cb), .o_valid(vb),
    .o_last(lb), .o_busy(busy_b), .o_done(done_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int s_cyc_a, s_cyc_b;
  int done_cyc_a = -1;
  int done_cyc_b = -1;
  int nv_a = 0;
  int nv_b = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_model(input bit b, input bit rev);
    int hbase, cbase, t, r;
    hbase = b ? 100 : 0;
    cbase = b ? 200 : 0;
    for (int i = 0; i < TS; i++) begin
      t = rev ? TS - 1 - i : i;
      r = t * NC;
      for (int j = 0; j < NC; j++)
        for (int k = 0; k < NC; k++) begin
          logic [11:0] eh, ec;
          logic el;
          eh = 12'(hbase + r + k);
          ec = 12'(cbase + r + j);
          el = (k == NC - 1);
          if (b) qb.push_back({7'd0, eh, ec, el});
          else   qa.push_back({7'd0, eh, ec, el});
        end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin : mon_a
    logic adv;
    adv = en_a & rst_n;
    #1;
    if (adv && va) begin
      if (qa.size() != 0) begin
        chk("a_hcl", {7'd0, ha, ca, la}, qa.pop_front());
        nv_a++;
      end else chk("a_extra_valid", {31'd0, va}, 32'd0);
    end
    if (done_a && done_cyc_a < 0) done_cyc_a = cyc;
  end

  always @(posedge clk) begin : mon_b
    logic adv;
    adv = en_b & rst_n;
    #1;
    if (adv && vb) begin
      if (qb.size() != 0) begin
        chk("b_hcl", {7'd0, hb, cb, lb}, qb.pop_front());
        nv_b++;
      end else chk("b_extra_valid", {31'd0, vb}, 32'd0);
    end
    if (done_b && done_cyc_b < 0) done_cyc_b = cyc;
  end

  task automatic go_a(input logic dir);
    @(negedge clk);
    start_a = 1'b1;
    dir_a = dir;
    done_cyc_a = -1;
    nv_a = 0;
    @(posedge clk);
    #1;
    s_cyc_a = cyc;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic go_b();
    @(negedge clk);
    start_b = 1'b1;
    done_cyc_b = -1;
    nv_b = 0;
    @(posedge clk);
    #1;
    s_cyc_b = cyc;
  endtask

  task automatic wait_done(input bit b, input int exp_lat);
    int n;
    n = 0;
    while ((b ? done_cyc_b : done_cyc_a) < 0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (b) begin
      chk("b_done_lat", done_cyc_b - s_cyc_b + 1, exp_lat);
      chk("b_busy_at_done", {31'd0, busy_b}, 32'd1);
      chk("b_nvalid", nv_b, NC * NC * TS);
      chk("b_q_empty", qb.size(), 0);
      @(posedge clk);
      #2;
      chk("b_done_pulse", {31'd0, done_b}, 32'd0);
      chk("b_idle", {31'd0, busy_b}, 32'd0);
    end else begin
      chk("a_done_lat", done_cyc_a - s_cyc_a + 1, exp_lat);
      chk("a_busy_at_done", {31'd0, busy_a}, 32'd1);
      chk("a_nvalid", nv_a, NC * NC * TS);
      chk("a_q_empty", qa.size(), 0);
      @(posedge clk);
      #2;
      chk("a_done_pulse", {31'd0, done_a}, 32'd0);
      chk("a_idle", {31'd0, busy_a}, 32'd0);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start_a = 1'b0; en_a = 1'b1; dir_a = 1'b0;
    start_b = 1'b0; en_b = 1'b1; dir_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_h", ha, 0);
    chk("rst_a_c", ca, 0);
    chk("rst_a_flags", {va, la, busy_a, done_a}, 0);
    chk("rst_b_h", hb, 100);
    chk("rst_b_c", cb, 200);
    chk("rst_b_flags", {vb, lb, busy_b, done_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // forward sweep; i_dir flipped mid-sweep must be ignored
    push_model(1'b0, 1'b0);
    go_a(1'b0);
    repeat (4) @(negedge clk);
    dir_a = 1'b1;
    wait_done(1'b0, 25);
    dir_a = 1'b0;

    // direction 1 start
`ifdef ADDR_GEN_HC_REVERSE_EN
    push_model(1'b0, 1'b1);
`else
    push_model(1'b0, 1'b0);
`endif
    go_a(1'b1);
    wait_done(1'b0, 25);

    // 5-cycle stall while o_addr_h=1
    push_model(1'b0, 1'b0);
    go_a(1'b0);
    n = 0;
    while (!(va && ha == 12'd1) && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("stall_found", ha, 1);
    @(negedge clk);
    en_a = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #2;
      chk("stall_h", ha, 1);
      chk("stall_vc", {va, ca}, {1'b1, 12'd0});
    end
    @(negedge clk);
    en_a = 1'b1;
    wait_done(1'b0, 30);

    // reset at the 10th valid cycle
    push_model(1'b0, 1'b0);
    go_a(1'b0);
    n = 0;
    while (nv_a < 10 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("rst_mid_nv", nv_a, 10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out", {va, la, busy_a, done_a, ha, ca}, 0);
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    chk("rst_no_done", done_cyc_a, -1);
    chk("rst_idle", {31'd0, busy_a}, 32'd0);
    push_model(1'b0, 1'b0);
    go_a(1'b0);
    wait_done(1'b0, 25);

    // DELAY=0: continuous valid, start while busy ignored
    push_model(1'b1, 1'b0);
    go_b();
    for (int i = 2; i <= NC * NC * TS; i++) begin
      @(negedge clk);
      start_b = (i == 5);
      @(posedge clk);
      #2;
      chk("b_cont_valid", {31'd0, vb}, 32'd1);
    end
    @(negedge clk);
    start_b = 1'b0;
    wait_done(1'b1, 19);
    repeat (3) begin
      @(posedge clk);
      #2;
      chk("b_no_restart", {31'd0, busy_b}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
